receptor_movimentos: RTL and testbench
======================================

Name: receptor_movimentos

Overview:
- Robot-side receiver for the solve-sequence phase of the serial link. The host sends a stream of movement bytes that ends with 0x00.
- Behaviour: requests the sequence by transmitting 0xFF through the UART transmitter, buffers each received movement code in a FIFO, then presents the codes one at a time to the movement executor over a valid/accept handshake.
- Position: between rx_serial_8N1 (byte input), the uart transmitter (request output) and the servo-sequencing FSM.

Parameters:
- PROFUNDIDADE, 32: FIFO depth in entries (power of two).
- MOV_MAX, 6: highest legal movement code; legal codes are 1..MOV_MAX.
- COD_REQ, 8'hFF: request byte transmitted to the host.
- COD_FIM, 8'h00: end-of-sequence byte.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low reset.
- iniciar  in  1  start or restart a reception; level, sampled each cycle.
- rx_pronto  in  1  one-cycle pulse: rx_dados holds a new byte.
- rx_dados  in  8  received byte.
- tx_partida  out  1  one-cycle start pulse to the uart.
- tx_dados  out  8  byte to transmit; always equal to COD_REQ.
- tx_pronto  in  1  uart finished transmitting.
- mov_valido  out  1  FIFO not empty; mov is valid.
- mov  out  3  movement code at the FIFO head.
- mov_aceito  in  1  executor consumes the head entry.
- fim  out  1  sequence complete and FIFO drained.
- erro  out  1  protocol or overflow error, sticky.
- db_contagem  out  6  total movements received in this sequence.
- db_estado  out  4  current state encoding.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to OCIOSO and the FIFO empties.
  - All outputs are 0, except tx_dados = COD_REQ.
  - Reset mid-operation discards all buffered moves.
- States and transitions:
  - OCIOSO: iniciar=1 -> ENVIA_REQ.
  - ENVIA_REQ: tx_partida=1 for exactly one cycle -> ESPERA_TX.
  - ESPERA_TX: tx_pronto=1 -> RECEBE. rx_pronto pulses arriving in this state are ignored.
  - RECEBE: on each rx_pronto:
    - byte == COD_FIM -> DESCARREGA.
    - 1 <= byte <= MOV_MAX -> push byte[2:0] to the FIFO and increment db_contagem (saturates at 63).
    - Any other byte (including 0x07..0xFE, and 0xFF) -> ERRO.
    - Push while full -> ERRO, unless a pop occurs in the same cycle; a simultaneous push and pop on a full FIFO is legal and count is unchanged.
  - DESCARREGA: FIFO empty -> FIM. Further rx_pronto pulses are ignored.
  - FIM: fim=1. iniciar=1 -> clear db_contagem and erro, go to ENVIA_REQ.
  - ERRO: erro=1. The FIFO is frozen: mov_valido=0 and pops are ignored. iniciar=1 -> flush FIFO, clear erro and db_contagem, go to ENVIA_REQ.
- Output handshake (all states except ERRO):
  - mov_valido = !vazio; mov = head entry, combinational from the FIFO read pointer.
  - A pop occurs in any cycle where mov_valido & mov_aceito are both 1.
  - mov stays stable while mov_valido=1 and mov_aceito=0.
  - Executor draining starts while reception is still in progress (in RECEBE).
- Latency:
  - A byte pushed at edge N gives mov_valido=1 after edge N when the FIFO was empty.
  - A pop at edge N presents the next entry after edge N.
- Simultaneous rx_pronto=COD_FIM and a pop of the last entry: go to DESCARREGA; FIM follows on the next edge.
- iniciar held high in FIM or ERRO: exactly one request per entry into ENVIA_REQ. iniciar is ignored in all other states.
- Pointers are log2(PROFUNDIDADE) bits wide and wrap modulo the depth. The occupancy counter is one bit wider than the pointers.

Decomposition:
- Package pkg_receptor_movimentos holds:
  - state encodings: OCIOSO=0, ENVIA_REQ=1, ESPERA_TX=2, RECEBE=3, DESCARREGA=4, FIM=5, ERRO=6;
  - default values of COD_REQ and COD_FIM.
- Sub-module fifo_sincrona (parameterized width and depth):
  - ports: push, pop, data in, data out, cheio, vazio, flush;
  - same synchronous active-low reset.
- The FSM and classifier stay in receptor_movimentos.

Test Plan:
1. Reset; iniciar=1 for 1 cycle -> exactly one tx_partida pulse with tx_dados=8'hFF; state moves to ESPERA_TX, then RECEBE after tx_pronto.
2. Bytes 01,02,03,00 with mov_aceito=0 -> db_contagem=3, mov=1, mov_valido=1, fim=0. Then pulse mov_aceito 3 times -> mov sequence 1,2,3, then mov_valido=0, fim=1 one edge later.
3. 32 bytes of 05 with no accepts, then a 33rd 05 -> erro=1 and mov_valido=0. Then iniciar=1 -> erro=0, FIFO empty, new 0xFF request sent.
4. Full FIFO (32 entries): 33rd byte 04 arrives in the same cycle as mov_aceito=1 -> no error, count remains 32, and the last entry read out is 4 (wrap-around is correct).
5. Byte 8'h09 in RECEBE -> ERRO. A subsequent rx byte 01 changes nothing.
6. reset=0 while in RECEBE with 5 buffered moves -> all outputs 0 next edge, mov_valido=0, db_estado=0.

Source files
------------

// File: rtl/receptor_movimentos_pkg.sv
// Shared encodings for the solve-sequence receiver: FSM states and link byte codes.
package pkg_receptor_movimentos;

    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        ENVIA_REQ  = 4'd1,
        ESPERA_TX  = 4'd2,
        RECEBE     = 4'd3,
        DESCARREGA = 4'd4,
        FIM        = 4'd5,
        ERRO       = 4'd6
    } estado_t;

    localparam logic [7:0] COD_REQ_PADRAO = 8'hFF;
    localparam logic [7:0] COD_FIM_PADRAO = 8'h00;

endpackage

// File: rtl/receptor_movimentos_fifo.sv
// Synchronous FIFO with flush; a push on a full FIFO is accepted only when a pop happens in the same cycle.
module fifo_sincrona #(
    parameter int LARGURA      = 3,
    parameter int PROFUNDIDADE = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [LARGURA-1:0] dado_entrada,
    output logic [LARGURA-1:0] dado_saida,
    output logic               cheio,
    output logic               vazio
);

    localparam int PW = $clog2(PROFUNDIDADE);

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PW-1:0]      ptr_esc;
    logic [PW-1:0]      ptr_leit;
    logic [PW:0]        ocupacao;
    logic               push_ef;
    logic               pop_ef;

    assign vazio      = (ocupacao == '0);
    assign cheio      = (ocupacao == (PW+1)'(PROFUNDIDADE));
    assign pop_ef     = pop && !vazio;
    assign push_ef    = push && (!cheio || pop_ef);
    assign dado_saida = mem[ptr_leit];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            ptr_esc  <= '0;
            ptr_leit <= '0;
            ocupacao <= '0;
        end else begin
            if (push_ef) ptr_esc  <= ptr_esc + PW'(1);
            if (pop_ef)  ptr_leit <= ptr_leit + PW'(1);
            case ({push_ef, pop_ef})
                2'b10:   ocupacao <= ocupacao + (PW+1)'(1);
                2'b01:   ocupacao <= ocupacao - (PW+1)'(1);
                default: ocupacao <= ocupacao;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ef) mem[ptr_esc] <= dado_entrada;
    end

endmodule

// File: rtl/receptor_movimentos.sv
// Requests the move sequence from the host, buffers legal move codes and hands them to the executor.
module receptor_movimentos
    import pkg_receptor_movimentos::*;
#(
    parameter int         PROFUNDIDADE = 32,
    parameter int         MOV_MAX      = 6,
    parameter logic [7:0] COD_REQ      = COD_REQ_PADRAO,
    parameter logic [7:0] COD_FIM      = COD_FIM_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       rx_pronto,
    input  logic [7:0] rx_dados,
    output logic       tx_partida,
    output logic [7:0] tx_dados,
    input  logic       tx_pronto,
    output logic       mov_valido,
    output logic [2:0] mov,
    input  logic       mov_aceito,
    output logic       fim,
    output logic       erro,
    output logic [5:0] db_contagem,
    output logic [3:0] db_estado
);

    estado_t estado;
    logic    cheio;
    logic    vazio;
    logic    pop;
    logic    push;
    logic    byte_legal;
    logic    reinicia;

    // Handshake: mov is valid whenever mov_valido=1; a pop happens on any
    // cycle with mov_valido & mov_aceito, and mov holds until then.
    assign mov_valido = !vazio && (estado != ERRO);
    assign pop        = mov_valido && mov_aceito;
    assign byte_legal = (rx_dados != 8'd0) && (rx_dados <= 8'(MOV_MAX));
    assign push       = (estado == RECEBE) && rx_pronto && (rx_dados != COD_FIM)
                        && byte_legal && (!cheio || pop);
    assign reinicia   = iniciar && ((estado == FIM) || (estado == ERRO));

    assign tx_dados   = COD_REQ;
    assign tx_partida = (estado == ENVIA_REQ);
    assign fim        = (estado == FIM);
    assign erro       = (estado == ERRO);
    assign db_estado  = estado;

    fifo_sincrona #(
        .LARGURA      (3),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .flush        (reinicia),
        .dado_entrada (rx_dados[2:0]),
        .dado_saida   (mov),
        .cheio        (cheio),
        .vazio        (vazio)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado      <= OCIOSO;
            db_contagem <= '0;
        end else begin
            case (estado)
                OCIOSO: if (iniciar) estado <= ENVIA_REQ;
                ENVIA_REQ: estado <= ESPERA_TX;
                ESPERA_TX: if (tx_pronto) estado <= RECEBE;
                RECEBE: begin
                    if (rx_pronto) begin
                        if (rx_dados == COD_FIM) begin
                            estado <= DESCARREGA;
                        end else if (!byte_legal || (cheio && !pop)) begin
                            estado <= ERRO;
                        end else if (db_contagem != 6'd63) begin
                            db_contagem <= db_contagem + 6'd1;
                        end
                    end
                end
                DESCARREGA: if (vazio) estado <= FIM;
                FIM, ERRO: begin
                    if (iniciar) begin
                        estado      <= ENVIA_REQ;
                        db_contagem <= '0;
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_receptor_movimentos.sv
// Directed-vector bench for receptor_movimentos.
module tb_receptor_movimentos;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       rx_pronto = 1'b0;
    logic [7:0] rx_dados = 8'h00;
    logic       tx_partida;
    logic [7:0] tx_dados;
    logic       tx_pronto = 1'b0;
    logic       mov_valido;
    logic [2:0] mov;
    logic       mov_aceito = 1'b0;
    logic       fim;
    logic       erro;
    logic [5:0] db_contagem;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    always #10 clock = ~clock;

    receptor_movimentos dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .rx_pronto   (rx_pronto),
        .rx_dados    (rx_dados),
        .tx_partida  (tx_partida),
        .tx_dados    (tx_dados),
        .tx_pronto   (tx_pronto),
        .mov_valido  (mov_valido),
        .mov         (mov),
        .mov_aceito  (mov_aceito),
        .fim         (fim),
        .erro        (erro),
        .db_contagem (db_contagem),
        .db_estado   (db_estado)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dados  = b;
        rx_pronto = 1'b1;
        tick();
        rx_pronto = 1'b0;
    endtask

    task automatic start_seq();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        tx_pronto = 1'b1;
        tick();
        tx_pronto = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        n_checks++; if (db_estado !== 4'd0) begin n_fail++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
        n_checks++; if (tx_dados !== 8'hFF) begin n_fail++; $display("FAIL reset_tx_dados: got %0h expected ff", tx_dados); end
        n_checks++; if ({tx_partida, mov_valido, fim, erro} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {tx_partida, mov_valido, fim, erro}); end
        n_checks++; if (db_contagem !== 6'd0) begin n_fail++; $display("FAIL reset_contagem: got %0d expected 0", db_contagem); end
        reset = 1'b1;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_checks++; if (tx_partida !== 1'b1 || tx_dados !== 8'hFF) begin n_fail++; $display("FAIL req_pulse: got %b/%0h expected 1/ff", tx_partida, tx_dados); end
        n_checks++; if (db_estado !== 4'd1) begin n_fail++; $display("FAIL req_estado: got %0d expected 1", db_estado); end
        tick();
        n_checks++; if (tx_partida !== 1'b0 || db_estado !== 4'd2) begin n_fail++; $display("FAIL espera_tx: got %b/%0d expected 0/2", tx_partida, db_estado); end
        send_byte(8'h01);
        n_checks++; if (db_estado !== 4'd2 || mov_valido !== 1'b0) begin n_fail++; $display("FAIL rx_ignored_espera: got %0d/%b expected 2/0", db_estado, mov_valido); end
        tx_pronto = 1'b1;
        tick();
        tx_pronto = 1'b0;
        n_checks++; if (db_estado !== 4'd3) begin n_fail++; $display("FAIL recebe_estado: got %0d expected 3", db_estado); end
    endtask

    task automatic test_basic_sequence();
        do_reset();
        start_seq();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h00);
        n_checks++; if (db_contagem !== 6'd3) begin n_fail++; $display("FAIL basic_contagem: got %0d expected 3", db_contagem); end
        n_checks++; if (mov !== 3'd1 || mov_valido !== 1'b1) begin n_fail++; $display("FAIL basic_head: got %0d/%b expected 1/1", mov, mov_valido); end
        n_checks++; if (fim !== 1'b0 || db_estado !== 4'd4) begin n_fail++; $display("FAIL basic_descarrega: got %b/%0d expected 0/4", fim, db_estado); end
        tick();
        tick();
        n_checks++; if (mov !== 3'd1) begin n_fail++; $display("FAIL basic_stable: got %0d expected 1", mov); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mov !== 3'(i + 1)) begin n_fail++; $display("FAIL basic_pop%0d: got %0d expected %0d", i, mov, i + 1); end
            mov_aceito = 1'b1;
            tick();
            mov_aceito = 1'b0;
        end
        n_checks++; if (mov_valido !== 1'b0 || fim !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b/%b expected 0/0", mov_valido, fim); end
        tick();
        n_checks++; if (fim !== 1'b1 || db_estado !== 4'd5) begin n_fail++; $display("FAIL basic_fim: got %b/%0d expected 1/5", fim, db_estado); end
    endtask

    task automatic test_overflow();
        int pulses;
        do_reset();
        start_seq();
        for (int i = 0; i < 32; i++) send_byte(8'h05);
        n_checks++; if (db_contagem !== 6'd32 || erro !== 1'b0 || mov_valido !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %0d/%b/%b expected 32/0/1", db_contagem, erro, mov_valido); end
        send_byte(8'h05);
        n_checks++; if (erro !== 1'b1 || mov_valido !== 1'b0 || db_estado !== 4'd6) begin n_fail++; $display("FAIL ovf_erro: got %b/%b/%0d expected 1/0/6", erro, mov_valido, db_estado); end
        mov_aceito = 1'b1;
        tick();
        mov_aceito = 1'b0;
        n_checks++; if (erro !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", erro); end
        pulses = 0;
        iniciar = 1'b1;
        tick();
        if (tx_partida === 1'b1) pulses++;
        n_checks++; if (erro !== 1'b0 || mov_valido !== 1'b0 || db_contagem !== 6'd0) begin n_fail++; $display("FAIL ovf_restart: got %b/%b/%0d expected 0/0/0", erro, mov_valido, db_contagem); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tx_partida === 1'b1) pulses++;
        end
        iniciar = 1'b0;
        n_checks++; if (pulses !== 1 || db_estado !== 4'd2) begin n_fail++; $display("FAIL ovf_one_request: got %0d/%0d expected 1/2", pulses, db_estado); end
    endtask

    task automatic test_full_simultaneous();
        logic [2:0] exp_v;
        do_reset();
        start_seq();
        exp_q.delete();
        for (int i = 0; i < 32; i++) begin
            exp_v = 3'((i % 6) + 1);
            exp_q.push_back(exp_v);
            send_byte({5'd0, exp_v});
        end
        rx_dados   = 8'h04;
        rx_pronto  = 1'b1;
        mov_aceito = 1'b1;
        tick();
        rx_pronto  = 1'b0;
        mov_aceito = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(3'd4);
        n_checks++; if (erro !== 1'b0 || db_contagem !== 6'd33) begin n_fail++; $display("FAIL full_simul: got %b/%0d expected 0/33", erro, db_contagem); end
        for (int i = 0; i < 32; i++) begin
            exp_v = exp_q.pop_front();
            n_checks++; if (mov_valido !== 1'b1 || mov !== exp_v) begin n_fail++; $display("FAIL full_drain%0d: got %b/%0d expected 1/%0d", i, mov_valido, mov, exp_v); end
            mov_aceito = 1'b1;
            tick();
            mov_aceito = 1'b0;
        end
        n_checks++; if (mov_valido !== 1'b0 || db_estado !== 4'd3) begin n_fail++; $display("FAIL full_empty: got %b/%0d expected 0/3", mov_valido, db_estado); end
    endtask

    task automatic test_bad_code();
        do_reset();
        start_seq();
        send_byte(8'h01);
        send_byte(8'h09);
        n_checks++; if (erro !== 1'b1 || db_estado !== 4'd6 || mov_valido !== 1'b0) begin n_fail++; $display("FAIL bad09: got %b/%0d/%b expected 1/6/0", erro, db_estado, mov_valido); end
        send_byte(8'h01);
        n_checks++; if (db_estado !== 4'd6 || db_contagem !== 6'd1 || mov_valido !== 1'b0) begin n_fail++; $display("FAIL bad_after: got %0d/%0d/%b expected 6/1/0", db_estado, db_contagem, mov_valido); end
        start_seq();
        send_byte(8'h06);
        n_checks++; if (mov_valido !== 1'b1 || mov !== 3'd6 || db_contagem !== 6'd1) begin n_fail++; $display("FAIL max_legal: got %b/%0d/%0d expected 1/6/1", mov_valido, mov, db_contagem); end
        send_byte(8'h07);
        n_checks++; if (erro !== 1'b1) begin n_fail++; $display("FAIL bad07: got %b expected 1", erro); end
        start_seq();
        send_byte(8'hFF);
        n_checks++; if (erro !== 1'b1) begin n_fail++; $display("FAIL badff: got %b expected 1", erro); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_seq();
        for (int i = 0; i < 5; i++) send_byte(8'h02);
        n_checks++; if (mov_valido !== 1'b1 || db_contagem !== 6'd5) begin n_fail++; $display("FAIL mid_loaded: got %b/%0d expected 1/5", mov_valido, db_contagem); end
        reset = 1'b0;
        tick();
        n_checks++; if ({tx_partida, mov_valido, fim, erro} !== 4'b0000 || db_contagem !== 6'd0 || db_estado !== 4'd0 || tx_dados !== 8'hFF) begin n_fail++; $display("FAIL mid_reset: got %b/%0d/%0d/%0h expected 0000/0/0/ff", {tx_partida, mov_valido, fim, erro}, db_contagem, db_estado, tx_dados); end
        reset = 1'b1;
        tick();
        n_checks++; if (mov_valido !== 1'b0 || db_estado !== 4'd0) begin n_fail++; $display("FAIL mid_after: got %b/%0d expected 0/0", mov_valido, db_estado); end
    endtask

    task automatic test_fim_with_pop();
        do_reset();
        start_seq();
        send_byte(8'h02);
        rx_dados   = 8'h00;
        rx_pronto  = 1'b1;
        mov_aceito = 1'b1;
        tick();
        rx_pronto  = 1'b0;
        mov_aceito = 1'b0;
        n_checks++; if (db_estado !== 4'd4 || mov_valido !== 1'b0) begin n_fail++; $display("FAIL fimpop_desc: got %0d/%b expected 4/0", db_estado, mov_valido); end
        tick();
        n_checks++; if (fim !== 1'b1) begin n_fail++; $display("FAIL fimpop_fim: got %b expected 1", fim); end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n_checks++; if (db_estado !== 4'd1 || db_contagem !== 6'd0 || fim !== 1'b0) begin n_fail++; $display("FAIL fim_restart: got %0d/%0d/%b expected 1/0/0", db_estado, db_contagem, fim); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_seq();
        mov_aceito = 1'b1;
        for (int i = 0; i < 65; i++) send_byte(8'h03);
        mov_aceito = 1'b0;
        n_checks++; if (db_contagem !== 6'd63 || erro !== 1'b0) begin n_fail++; $display("FAIL saturate: got %0d/%b expected 63/0", db_contagem, erro); end
        n_checks++; if (mov_valido !== 1'b1 || mov !== 3'd3) begin n_fail++; $display("FAIL b2b_head: got %b/%0d expected 1/3", mov_valido, mov); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_sequence();
        test_overflow();
        test_full_simultaneous();
        test_bad_code();
        test_reset_mid();
        test_fim_with_pop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
